// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared RV32I fetch constants and state encoding
package fetch_unit_pkg;
    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] INVALID_PC = 32'hFFFF_FFFF;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    typedef enum logic [1:0] {ISSUE, WAIT, HOLD, DROP} state_e;
endpackage

// File: rtl/fetch_unit_predecode.sv
// branch_predecode: static prediction (JAL taken, backward branch taken) and next PC
module branch_predecode
    import fetch_unit_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ILEN = 32
) (
    input  logic [ILEN-1:0] i_inst,
    input  logic [XLEN-1:0] i_addr,
    output logic            o_taken,
    output logic [XLEN-1:0] o_next_pc
);
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm_j;
    logic            w_is_jal;
    logic            w_is_bwd;

    assign w_imm_b = {{(XLEN-12){i_inst[31]}}, i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
    assign w_imm_j = {{(XLEN-20){i_inst[31]}}, i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
    assign w_is_jal = i_inst[6:0] == OP_JAL;
    assign w_is_bwd = (i_inst[6:0] == OP_BRANCH) && i_inst[31];

    // taken targets use the decoded immediate; everything else falls through, wrapping silently
    always_comb begin
        o_taken = w_is_jal | w_is_bwd;
        o_next_pc = i_addr + (w_is_jal ? w_imm_j : w_is_bwd ? w_imm_b : XLEN'(4));
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, single-outstanding imem reads, output slot plus one-entry skid buffer
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              ILEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_ready,
    input  logic            i_imem_rvalid,
    input  logic [ILEN-1:0] i_imem_rdata,
    input  logic            i_du_stall,
    input  logic            i_exec_flush,
    input  logic [XLEN-1:0] i_exec_target,
    output logic [ILEN-1:0] o_du_inst,
    output logic [XLEN-1:0] o_du_addr,
    output logic            o_du_branch_taken
);
    typedef struct packed {
        logic [ILEN-1:0] inst;
        logic [XLEN-1:0] addr;
        logic            taken;
        logic            valid;
    } slot_t;

    localparam slot_t EMPTY = '0;

    state_e          r_state;
    state_e          w_next_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_next_pc;
    slot_t           r_out;
    slot_t           r_skid;
    slot_t           w_new;
    logic            w_taken;
    logic            w_xfer;
    logic            w_cap;
    logic            w_outstanding;

    assign w_xfer = o_imem_req & i_imem_ready;
    assign w_cap = (r_state == WAIT) & i_imem_rvalid;
    // a request transferring in the same cycle as a flush is in flight and must be dropped
    assign w_outstanding = (r_state == WAIT) | (r_state == DROP) | w_xfer;
    assign w_new = {i_imem_rdata, r_pc, w_taken, 1'b1};

    branch_predecode #(.XLEN(XLEN), .ILEN(ILEN)) u_predecode (
        .i_inst   (i_imem_rdata),
        .i_addr   (r_pc),
        .o_taken  (w_taken),
        .o_next_pc(w_next_pc)
    );

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ISSUE;
        else r_state <= w_next_state;
    end

    // next state: flush overrides every other transition
    always_comb begin
        w_next_state = r_state;
        if (i_exec_flush) w_next_state = (w_outstanding && !i_imem_rvalid) ? DROP : ISSUE;
        else begin
            case (r_state)
                ISSUE: w_next_state = w_xfer ? WAIT : ISSUE;
                WAIT:  w_next_state = !i_imem_rvalid ? WAIT : (i_du_stall && r_out.valid) ? HOLD : ISSUE;
                HOLD:  w_next_state = i_du_stall ? HOLD : ISSUE;
                DROP:  w_next_state = i_imem_rvalid ? ISSUE : DROP;
                default: w_next_state = ISSUE;
            endcase
        end
    end

    // outputs: request only in ISSUE, empty output slot shows a bubble
    always_comb begin
        o_imem_req = (r_state == ISSUE) && !rst;
        o_imem_addr = r_pc;
        o_du_inst = r_out.valid ? r_out.inst : ILEN'(NOP);
        o_du_addr = r_out.valid ? r_out.addr : XLEN'(INVALID_PC);
        o_du_branch_taken = r_out.valid & r_out.taken;
    end

    // PC follows redirects and the predicted successor of each captured word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_pc <= RESET_PC;
        else if (i_exec_flush) r_pc <= i_exec_target & ~XLEN'(3);
        else if (w_cap) r_pc <= w_next_pc & ~XLEN'(3);
    end

    // output slot and skid buffer; skid only fills when the slot is full and stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst || i_exec_flush) begin
            r_out <= EMPTY;
            r_skid <= EMPTY;
        end else if (!i_du_stall) begin
            r_out <= r_skid.valid ? r_skid : w_cap ? w_new : EMPTY;
            r_skid <= EMPTY;
        end else if (w_cap) begin
            if (r_out.valid) r_skid <= w_new;
            else r_out <= w_new;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against hand-computed sequences
module tb_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] INV = 32'hFFFF_FFFF;
    localparam logic [31:0] ADDI = 32'h0010_0093;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ready = 1'b0;
    logic        i_imem_rvalid = 1'b0;
    logic [31:0] i_imem_rdata = 32'h0;
    logic        i_du_stall = 1'b0;
    logic        i_exec_flush = 1'b0;
    logic [31:0] i_exec_target = 32'h0;
    logic [31:0] o_du_inst;
    logic [31:0] o_du_addr;
    logic        o_du_branch_taken;

    logic [31:0] mem [0:1023];
    int          lat = 1;
    logic        pend = 1'b0;
    logic [31:0] paddr = 32'h0;
    int          cnt = 0;
    int          n_cmp = 0;
    int          n_fail = 0;

    fetch_unit dut (
        .clk              (clk),
        .rst              (rst),
        .o_imem_req       (o_imem_req),
        .o_imem_addr      (o_imem_addr),
        .i_imem_ready     (i_imem_ready),
        .i_imem_rvalid    (i_imem_rvalid),
        .i_imem_rdata     (i_imem_rdata),
        .i_du_stall       (i_du_stall),
        .i_exec_flush     (i_exec_flush),
        .i_exec_target    (i_exec_target),
        .o_du_inst        (o_du_inst),
        .o_du_addr        (o_du_addr),
        .o_du_branch_taken(o_du_branch_taken)
    );

    always #5 clk = ~clk;

    // memory: one response, lat cycles after the transfer, lost on reset
    always @(posedge clk) begin
        logic        fire;
        logic [31:0] a;
        fire = !rst && o_imem_req && i_imem_ready;
        a = o_imem_addr;
        #1;
        if (rst) begin
            pend = 1'b0;
            i_imem_rvalid = 1'b0;
        end else begin
            if (i_imem_rvalid) pend = 1'b0;
            i_imem_rvalid = 1'b0;
            if (fire) begin
                pend = 1'b1;
                paddr = a;
                cnt = lat;
            end
            if (pend) begin
                if (cnt <= 1) begin
                    i_imem_rvalid = 1'b1;
                    i_imem_rdata = mem[paddr[11:2]];
                end else cnt--;
            end
        end
    end

    task automatic quiesce_redirect(input logic [31:0] t);
        i_imem_ready = 1'b0;
        lat = 1;
        repeat (5) @(negedge clk);
        i_exec_flush = 1'b1;
        i_exec_target = t;
        @(negedge clk);
        i_exec_flush = 1'b0;
        i_imem_ready = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++; if (o_imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", o_imem_req); end
        n_cmp++; if (o_imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 00000000", o_imem_addr); end
        n_cmp++; if (o_du_inst !== NOP) begin n_fail++; $display("FAIL reset_inst: got %h want %h", o_du_inst, NOP); end
        n_cmp++; if (o_du_addr !== INV) begin n_fail++; $display("FAIL reset_du_addr: got %h want %h", o_du_addr, INV); end
        n_cmp++; if (o_du_branch_taken !== 1'b0) begin n_fail++; $display("FAIL reset_taken: got %b want 0", o_du_branch_taken); end
        rst = 1'b0;
        i_imem_ready = 1'b1;
        #1;
        n_cmp++; if (o_imem_req !== 1'b1) begin n_fail++; $display("FAIL first_req: got %b want 1", o_imem_req); end
        n_cmp++; if (o_imem_addr !== 32'h0) begin n_fail++; $display("FAIL first_addr: got %h want 00000000", o_imem_addr); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_du [6] = '{INV, 32'h0, INV, 32'h4, INV, 32'h8};
        logic        exp_req [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] exp_addr [6] = '{32'h0, 32'h4, 32'h0, 32'h8, 32'h0, 32'hC};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_cmp++; if (o_du_addr !== exp_du[i]) begin n_fail++; $display("FAIL seq_du_addr[%0d]: got %h want %h", i, o_du_addr, exp_du[i]); end
            n_cmp++; if (o_imem_req !== exp_req[i]) begin n_fail++; $display("FAIL seq_req[%0d]: got %b want %b", i, o_imem_req, exp_req[i]); end
            if (exp_req[i]) begin
                n_cmp++; if (o_imem_addr !== exp_addr[i]) begin n_fail++; $display("FAIL seq_addr[%0d]: got %h want %h", i, o_imem_addr, exp_addr[i]); end
            end
        end
    endtask

    task automatic test_ready_low();
        i_imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (o_imem_req !== 1'b1) begin n_fail++; $display("FAIL stable_req[%0d]: got %b want 1", i, o_imem_req); end
            n_cmp++; if (o_imem_addr !== 32'hC) begin n_fail++; $display("FAIL stable_addr[%0d]: got %h want 0000000c", i, o_imem_addr); end
        end
    endtask

    task automatic test_predict();
        logic [31:0] pcs [4] = '{32'h10, 32'h20, 32'h40, 32'hFFFF_FFF0};
        logic [31:0] insts [4] = '{32'hFE00_0CE3, 32'h0000_1863, 32'h1000_006F, 32'h1000_006F};
        logic [31:0] nexts [4] = '{32'h08, 32'h24, 32'h140, 32'h0000_00F0};
        logic        takens [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            mem[pcs[i][11:2]] = insts[i];
            quiesce_redirect(pcs[i]);
            n_cmp++; if (o_imem_addr !== pcs[i] || o_imem_req !== 1'b1) begin n_fail++; $display("FAIL pred_req[%0d]: got %b/%h want 1/%h", i, o_imem_req, o_imem_addr, pcs[i]); end
            @(negedge clk);
            n_cmp++; if (o_du_addr !== INV) begin n_fail++; $display("FAIL pred_bubble[%0d]: got %h want %h", i, o_du_addr, INV); end
            @(negedge clk);
            n_cmp++; if (o_du_addr !== pcs[i]) begin n_fail++; $display("FAIL pred_du_addr[%0d]: got %h want %h", i, o_du_addr, pcs[i]); end
            n_cmp++; if (o_du_inst !== insts[i]) begin n_fail++; $display("FAIL pred_inst[%0d]: got %h want %h", i, o_du_inst, insts[i]); end
            n_cmp++; if (o_du_branch_taken !== takens[i]) begin n_fail++; $display("FAIL pred_taken[%0d]: got %b want %b", i, o_du_branch_taken, takens[i]); end
            n_cmp++; if (o_imem_req !== 1'b1) begin n_fail++; $display("FAIL pred_next_req[%0d]: got %b want 1", i, o_imem_req); end
            n_cmp++; if (o_imem_addr !== nexts[i]) begin n_fail++; $display("FAIL pred_next_pc[%0d]: got %h want %h", i, o_imem_addr, nexts[i]); end
        end
    endtask

    task automatic test_stall();
        quiesce_redirect(32'h0);
        i_du_stall = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (o_du_addr !== 32'h0) begin n_fail++; $display("FAIL stall_first: got %h want 00000000", o_du_addr); end
        n_cmp++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h4) begin n_fail++; $display("FAIL stall_second_req: got %b/%h want 1/00000004", o_imem_req, o_imem_addr); end
        @(negedge clk);
        n_cmp++; if (o_imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_wait_req: got %b want 0", o_imem_req); end
        @(negedge clk);
        n_cmp++; if (o_du_addr !== 32'h0) begin n_fail++; $display("FAIL stall_hold_a: got %h want 00000000", o_du_addr); end
        n_cmp++; if (o_imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_no_third_a: got %b want 0", o_imem_req); end
        @(negedge clk);
        n_cmp++; if (o_du_addr !== 32'h0) begin n_fail++; $display("FAIL stall_hold_b: got %h want 00000000", o_du_addr); end
        n_cmp++; if (o_imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_no_third_b: got %b want 0", o_imem_req); end
        n_cmp++; if (o_du_inst !== ADDI) begin n_fail++; $display("FAIL stall_inst: got %h want %h", o_du_inst, ADDI); end
        i_du_stall = 1'b0;
        @(negedge clk);
        n_cmp++; if (o_du_addr !== 32'h4) begin n_fail++; $display("FAIL stall_skid_out: got %h want 00000004", o_du_addr); end
        n_cmp++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h8) begin n_fail++; $display("FAIL stall_resume_req: got %b/%h want 1/00000008", o_imem_req, o_imem_addr); end
        @(negedge clk);
        n_cmp++; if (o_du_addr !== INV) begin n_fail++; $display("FAIL stall_bubble: got %h want %h", o_du_addr, INV); end
    endtask

    task automatic test_flush_wait();
        int waited;
        quiesce_redirect(32'h80);
        lat = 3;
        @(negedge clk);
        i_exec_flush = 1'b1;
        i_exec_target = 32'h202;
        @(negedge clk);
        i_exec_flush = 1'b0;
        n_cmp++; if (o_du_addr !== INV) begin n_fail++; $display("FAIL fw_bubble: got %h want %h", o_du_addr, INV); end
        n_cmp++; if (o_imem_req !== 1'b0) begin n_fail++; $display("FAIL fw_drop_req: got %b want 0", o_imem_req); end
        waited = 0;
        while (waited < 10 && !(waited > 0 && o_imem_req)) begin
            @(negedge clk);
            waited++;
            n_cmp++; if (o_du_addr !== INV) begin n_fail++; $display("FAIL fw_gap_bubble[%0d]: got %h want %h", waited, o_du_addr, INV); end
        end
        lat = 1;
        n_cmp++; if (waited !== 2) begin n_fail++; $display("FAIL fw_req_delay: got %0d cycles want 2", waited); end
        n_cmp++; if (o_imem_addr !== 32'h200) begin n_fail++; $display("FAIL fw_target: got %h want 00000200", o_imem_addr); end
        repeat (2) @(negedge clk);
        n_cmp++; if (o_du_addr !== 32'h200) begin n_fail++; $display("FAIL fw_resume: got %h want 00000200", o_du_addr); end
    endtask

    task automatic test_flush_rvalid_stall();
        mem[192] = 32'h0020_0113;
        quiesce_redirect(32'h0);
        i_du_stall = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (o_du_addr !== 32'h0) begin n_fail++; $display("FAIL fr_pre: got %h want 00000000", o_du_addr); end
        @(negedge clk);
        i_exec_flush = 1'b1;
        i_exec_target = 32'h300;
        @(negedge clk);
        i_exec_flush = 1'b0;
        i_du_stall = 1'b0;
        n_cmp++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h300) begin n_fail++; $display("FAIL fr_req: got %b/%h want 1/00000300", o_imem_req, o_imem_addr); end
        n_cmp++; if (o_du_addr !== INV) begin n_fail++; $display("FAIL fr_bubble_addr: got %h want %h", o_du_addr, INV); end
        n_cmp++; if (o_du_inst !== NOP) begin n_fail++; $display("FAIL fr_bubble_inst: got %h want %h", o_du_inst, NOP); end
        n_cmp++; if (o_du_branch_taken !== 1'b0) begin n_fail++; $display("FAIL fr_bubble_taken: got %b want 0", o_du_branch_taken); end
        @(negedge clk);
        n_cmp++; if (o_du_addr !== INV) begin n_fail++; $display("FAIL fr_skid_empty: got %h want %h", o_du_addr, INV); end
        @(negedge clk);
        n_cmp++; if (o_du_addr !== 32'h300 || o_du_inst !== 32'h0020_0113) begin n_fail++; $display("FAIL fr_target_out: got %h/%h want 00000300/00200113", o_du_addr, o_du_inst); end
    endtask

    task automatic test_reset_mid();
        quiesce_redirect(32'h40);
        lat = 3;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++; if (o_imem_req !== 1'b0 || o_imem_addr !== 32'h0) begin n_fail++; $display("FAIL mid_rst_req: got %b/%h want 0/00000000", o_imem_req, o_imem_addr); end
        n_cmp++; if (o_du_addr !== INV) begin n_fail++; $display("FAIL mid_rst_du: got %h want %h", o_du_addr, INV); end
        @(negedge clk);
        lat = 1;
        rst = 1'b0;
        #1;
        n_cmp++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0) begin n_fail++; $display("FAIL mid_restart: got %b/%h want 1/00000000", o_imem_req, o_imem_addr); end
        repeat (2) @(negedge clk);
        n_cmp++; if (o_du_addr !== 32'h0 || o_du_inst !== ADDI) begin n_fail++; $display("FAIL mid_first_out: got %h/%h want 00000000/%h", o_du_addr, o_du_inst, ADDI); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = ADDI;
        test_reset();
        test_sequential();
        test_ready_low();
        test_predict();
        test_stall();
        test_flush_wait();
        test_flush_rvalid_stall();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RV32I pipeline. Holds the PC and issues one-outstanding-request reads to instruction memory. Applies static prediction: backward-taken/forward-not-taken for conditional branches, always-taken for JAL. Presents one instruction per cycle to the decode stage as `inst`/`addr`/`branch_taken`, and inserts `nop`/`invalid_pc` bubbles whenever no valid instruction is available.

## Interface
Parameters:
- `XLEN`, 32, address/data width
- `ILEN`, 32, instruction width
- `RESET_PC`, 32'h0000_0000, first fetch address after reset

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `o_imem_req`  out  1  read request valid
- `o_imem_addr`  out  XLEN  read address, word aligned
- `i_imem_ready`  in  1  memory accepts request (transfer = req & ready)
- `i_imem_rvalid`  in  1  read data valid; exactly one per transfer, in order, ≥1 cycle after it
- `i_imem_rdata`  in  ILEN  instruction word
- `i_du_stall`  in  1  decode not consuming; hold outputs
- `i_exec_flush`  in  1  redirect; discard everything in flight
- `i_exec_target`  in  XLEN  redirect PC, bits [1:0] ignored (forced 00)
- `o_du_inst`  out  ILEN  instruction to decode
- `o_du_addr`  out  XLEN  PC of `o_du_inst`
- `o_du_branch_taken`  out  1  fetch predicted this instruction taken

## Operation
- State machine states:
  - ISSUE: `o_imem_req`=1, `o_imem_addr`=pc. On transfer, go to WAIT.
  - WAIT: one request outstanding. On `i_imem_rvalid`, capture the response and go to ISSUE (or HOLD if the skid buffer is now full).
  - HOLD: skid buffer full; no request issued. When the skid buffer drains, go to ISSUE.
  - DROP: flush arrived while a request was outstanding. The next `i_imem_rvalid` is discarded, then go to ISSUE.
- Output slot plus one-entry skid buffer, each holding {inst, addr, taken, valid}.
  - Response with output slot free, or being consumed this cycle (`!i_du_stall`): response goes to the output slot.
  - Response otherwise: response goes to the skid buffer.
  - Skid buffer moves to the output slot when the slot is consumed.
- Empty output slot drives `nop` (32'h0000_0013), `invalid_pc`, and taken=0. A consumed slot with nothing to refill it becomes empty.
- `i_du_stall`: output slot and skid buffer hold. Requests continue while the skid buffer is empty.
- Next PC, computed on response capture from `i_imem_rdata` and its address a:
  - JAL: a + imm_J, taken=1.
  - BRANCH with imm_B[31]=1: a + imm_B, taken=1.
  - Anything else: a + 4, taken=0.
  - Adds are modulo 2^XLEN (wrap silently). JALR is never predicted.
- `i_exec_flush` has priority over everything, including stall and `i_imem_rvalid` in the same cycle:
  - Output slot and skid buffer are cleared to empty; pc <= target.
  - Request outstanding, no rvalid this cycle: go to DROP.
  - Otherwise: go to ISSUE, with no outstanding request.
  - A request not yet transferred is retargeted without needing a transfer.
- While `o_imem_req`=1 and `i_imem_ready`=0, `o_imem_addr` stays stable, except when a flush retargets it.

## Timing
- Reset values:
  - `o_imem_req`=0, `o_imem_addr`=`RESET_PC`
  - `o_du_inst`=`nop`, `o_du_addr`=`invalid_pc`, `o_du_branch_taken`=0
  - state=ISSUE, slots empty
- First request in the first cycle after `rst` falls: `o_imem_req`=1.
- Response to output: `rvalid` at edge N gives `o_du_*` valid from N+1.
- Response to next request: next `o_imem_req` asserted the cycle after `rvalid`.
  - Peak throughput 1 instruction per 2 cycles with 1-cycle memory latency.
- Flush at edge N:
  - `o_du_*` is a bubble from N+1.
  - Request for the target is asserted from N+1 (ISSUE case) or after the dropped response (DROP case).
- `rst` mid-request: the outstanding response is lost. Memory must also be reset; after reset, fetch restarts at `RESET_PC`.

## Structure
- Shared macros header: opcode constants (`BRANCH`, `JAL`), `nop`, `invalid_pc`, `XLEN`/`ILEN` (already present); add `RESET_PC` default.
- Sub-module `branch_predecode`:
  - Purely combinational.
  - Inputs: inst, addr.
  - Outputs: taken, next_pc. Computes imm_B/imm_J.

## Test plan
- Reset release, memory ready=1, latency 1, program of ADDIs at 0x0:
  - Addresses 0x0, 0x4, 0x8 requested in order.
  - `o_du_addr` sequence: 0x0, invalid, 0x4, ...
- `beq` at 0x10 with imm −8 -> next request 0x08, `o_du_branch_taken`=1. `bne` at 0x20 with imm +16 -> next request 0x24, taken=0.
- `jal` at 0x40 with imm +0x100 -> next request 0x140, taken=1.
- `i_du_stall` held 5 cycles with 2 responses arriving:
  - First response held in the output slot, second in the skid buffer, no third request.
  - On stall release: outputs 0x0, then 0x4, then a bubble.
- Flush to 0x200 while WAIT:
  - Next rvalid (data for the old PC) discarded.
  - Next request address 0x200; `o_du_*` shows only bubbles in between.
- Flush to 0x300 in the same cycle as `i_imem_rvalid` and `i_du_stall`=1:
  - Response dropped, slots emptied.
  - `o_imem_addr`=0x300 with req=1 on the next cycle.
